// File: rtl/fuzzy_pkg.sv
// Shared types and constants for the 3x3 singleton defuzzifier.
// Rule index is 3*T_term + D_term; the singleton table follows that order.
package fuzzy_pkg;

    localparam int W_W     = 16;
    localparam int NUM_W   = 36;
    localparam int DEN_W   = 20;
    localparam int Q_W     = 17;
    localparam int N_RULES = 9;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ACC  = 2'd1,
        S_DIV  = 2'd2,
        S_DONE = 2'd3
    } state_e;

    localparam logic signed [15:0] NB = -16'sd30000;
    localparam logic signed [15:0] NS = -16'sd15000;
    localparam logic signed [15:0] ZE =  16'sd0;
    localparam logic signed [15:0] PS =  16'sd15000;
    localparam logic signed [15:0] PB =  16'sd30000;

    function automatic logic signed [15:0] singleton(input logic [3:0] r);
        case (r)
            4'd0:       singleton = NB;
            4'd1, 4'd3: singleton = NS;
            4'd5, 4'd7: singleton = PS;
            4'd8:       singleton = PB;
            default:    singleton = ZE;
        endcase
    endfunction

endpackage

// File: rtl/divu_serial.sv
// Restoring unsigned divider, one quotient bit per cycle, MSB first.
// The first bit is resolved on the start edge, so done follows 17 edges after start.
module divu_serial
    import fuzzy_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [NUM_W-1:0] dividend,
    input  logic [DEN_W-1:0] divisor,
    output logic [Q_W-1:0]   quotient,
    output logic             done
);

    logic [NUM_W-1:0] rem_q, rem_cur, rem_d;
    logic [NUM_W-1:0] dsh_q, dsh_cur;
    logic [Q_W-1:0]   quot_q;
    logic [4:0]       cnt_q;
    logic             busy_q;
    logic             done_q;
    logic             ge;

    // Quotient is known to fit in Q_W bits, so the divisor starts aligned at bit Q_W-1.
    always_comb begin
        rem_cur = start ? dividend : rem_q;
        dsh_cur = start ? {divisor, {(Q_W-1){1'b0}}} : dsh_q;
        ge      = (rem_cur >= dsh_cur);
        rem_d   = ge ? (rem_cur - dsh_cur) : rem_cur;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem_q  <= '0;
            dsh_q  <= '0;
            quot_q <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (start) begin
                rem_q  <= rem_d;
                dsh_q  <= dsh_cur >> 1;
                quot_q <= {{(Q_W-1){1'b0}}, ge};
                cnt_q  <= 5'(Q_W-1);
                busy_q <= 1'b1;
            end else if (busy_q) begin
                rem_q  <= rem_d;
                dsh_q  <= dsh_cur >> 1;
                quot_q <= {quot_q[Q_W-2:0], ge};
                cnt_q  <= cnt_q - 5'd1;
                if (cnt_q == 5'd1) begin
                    busy_q <= 1'b0;
                    done_q <= 1'b1;
                end
            end
        end
    end

    assign quotient = quot_q;
    assign done     = done_q;

endmodule

// File: rtl/defuzz9.sv
// Weighted-average defuzzifier over nine rule weights with fixed 27-cycle latency.
// Serial multiply-accumulate (9 cycles) followed by a serial divide (17 cycles).
module defuzz9
    import fuzzy_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [W_W-1:0]       w00,
    input  logic [W_W-1:0]       w01,
    input  logic [W_W-1:0]       w02,
    input  logic [W_W-1:0]       w10,
    input  logic [W_W-1:0]       w11,
    input  logic [W_W-1:0]       w12,
    input  logic [W_W-1:0]       w20,
    input  logic [W_W-1:0]       w21,
    input  logic [W_W-1:0]       w22,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic signed [15:0]   y,
    output logic                 den_zero,
    output logic                 out_valid,
    input  logic                 out_ready,
    output state_e               state_dbg
);

    state_e                  state_q;
    logic [W_W-1:0]          w_q [N_RULES];
    logic [3:0]              idx_q;
    logic signed [NUM_W-1:0] num_q;
    logic [DEN_W-1:0]        den_q;
    logic                    start_q;
    logic signed [15:0]      y_q;
    logic                    den_zero_q;
    logic                    out_valid_q;

    logic [W_W-1:0]          w_cur;
    logic signed [32:0]      prod_raw;
    logic signed [NUM_W-1:0] prod_d;
    logic [NUM_W-1:0]        num_abs;
    logic [Q_W-1:0]          quot;
    logic                    div_done;
    logic signed [Q_W:0]     q_signed;
    logic signed [15:0]      y_d;

    always_comb begin
        w_cur    = w_q[idx_q];
        prod_raw = $signed({1'b0, w_cur}) * singleton(idx_q);
        prod_d   = NUM_W'(prod_raw);
        num_abs  = num_q[NUM_W-1] ? NUM_W'(-num_q) : NUM_W'(num_q);
        q_signed = num_q[NUM_W-1] ? -$signed({1'b0, quot}) : $signed({1'b0, quot});
        if (q_signed > 18'sd32767)
            y_d = 16'sh7FFF;
        else if (q_signed < -18'sd32768)
            y_d = -16'sd32768;
        else
            y_d = q_signed[15:0];
    end

    divu_serial u_div (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start_q),
        .dividend (num_abs),
        .divisor  (den_q),
        .quotient (quot),
        .done     (div_done)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            for (int i = 0; i < N_RULES; i++) w_q[i] <= '0;
            idx_q       <= '0;
            num_q       <= '0;
            den_q       <= '0;
            start_q     <= 1'b0;
            y_q         <= '0;
            den_zero_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            start_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (in_valid) begin
                        w_q[0]  <= w00;
                        w_q[1]  <= w01;
                        w_q[2]  <= w02;
                        w_q[3]  <= w10;
                        w_q[4]  <= w11;
                        w_q[5]  <= w12;
                        w_q[6]  <= w20;
                        w_q[7]  <= w21;
                        w_q[8]  <= w22;
                        idx_q   <= '0;
                        num_q   <= '0;
                        den_q   <= '0;
                        state_q <= S_ACC;
                    end
                end
                S_ACC: begin
                    num_q <= num_q + prod_d;
                    den_q <= den_q + DEN_W'(w_cur);
                    idx_q <= idx_q + 4'd1;
                    if (idx_q == 4'(N_RULES-1)) begin
                        start_q <= 1'b1;
                        state_q <= S_DIV;
                    end
                end
                S_DIV: begin
                    // A zero denominator still runs the full divide to keep latency fixed.
                    if (div_done) begin
                        y_q         <= (den_q == '0) ? 16'sd0 : y_d;
                        den_zero_q  <= (den_q == '0);
                        out_valid_q <= 1'b1;
                        state_q     <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign y         = y_q;
    assign den_zero  = den_zero_q;
    assign out_valid = out_valid_q;
    assign state_dbg = state_q;

endmodule

// File: doc/defuzz9.md
DEFUZZ9 -- requirements
Module: defuzz9

Interface
REQ-001 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port: rst_n  input  1  asynchronous, active-low reset.
REQ-003 SHALL have ports: w00,w01,w02,w10,w11,w12,w20,w21,w22  input  16 each  unsigned rule weights (0x0000=0.0, 0xFFFF≈1.0), index = 3*T_term + D_term.
REQ-004 SHALL have port: in_valid  input  1  weight set presented.
REQ-005 SHALL have port: in_ready  output  1  block can accept a weight set.
REQ-006 SHALL have port: y  output  16  signed crisp output, two's complement.
REQ-007 SHALL have port: den_zero  output  1  all nine weights were zero for this result.
REQ-008 SHALL have port: out_valid  output  1  y and den_zero valid.
REQ-009 SHALL have port: out_ready  input  1  consumer accepts result.

Function
REQ-010 SHALL compute y = trunc_toward_zero( sum(w_r*C[r]) / sum(w_r) ), r=0..8, where C is the singleton table of REQ-028.
REQ-011 SHALL implement FSM states IDLE, ACC, DIV, DONE.
REQ-012 SHALL assert in_ready only in IDLE; accept when in_valid&&in_ready; register all nine weights on the accepting edge and go to ACC.
REQ-013 ACC SHALL process one weight per cycle in order r=0..8 (9 cycles): num += signed(w_r)*C[r] (36-bit signed), den += w_r (20-bit unsigned); both cleared on accept.
REQ-014 After r=8 SHALL go to DIV; DIV SHALL run a restoring divide of |num| by den producing a 17-bit unsigned quotient, one bit per cycle, 17 cycles, in sub-module divu_serial.
REQ-015 SHALL negate the quotient when num<0, then saturate to [-32768, +32767] before loading y.
REQ-016 If den==0 after ACC, SHALL still spend 17 DIV cycles, force y=0 and den_zero=1; otherwise den_zero=0.
REQ-017 SHALL assert out_valid exactly 27 cycles after the accepting edge (1+9+17), entering DONE; latency SHALL be data-independent.
REQ-018 In DONE, y, den_zero and out_valid SHALL hold stable until out_valid&&out_ready; then go to IDLE with out_valid deasserted the next cycle.
REQ-019 SHALL NOT accept a new set while out_valid is high (no same-cycle done/accept overlap); throughput one result per ≥28 cycles.
REQ-020 Input weights SHALL be ignored outside the accepting edge; changes during ACC/DIV SHALL not affect the result.
REQ-021 in_valid without in_ready SHALL have no effect; in_valid need not be held.

Reset
REQ-022 On rst_n low, SHALL asynchronously enter IDLE with in_ready=1, out_valid=0, y=0, den_zero=0, num=0, den=0, divider cleared.
REQ-023 Reset asserted mid-ACC/DIV/DONE SHALL abort the computation; no out_valid SHALL follow for the aborted set.
REQ-024 First accept SHALL be possible on the first rising edge after rst_n deasserts.

Structure
REQ-025 Shared package fuzzy_pkg SHALL hold: weight width (16), state enum type, NUM_W=36, DEN_W=20, and singleton constants.
REQ-026 Sub-module divu_serial (start, dividend 36b, divisor 20b, quotient 17b, done) SHALL be the only sub-module.
REQ-027 No combinational path SHALL exist from any input to y/out_valid; in_ready SHALL be decoded from state only.
REQ-028 Singletons in fuzzy_pkg SHALL be NB=-30000, NS=-15000, ZE=0, PS=15000, PB=30000; C = {w00:NB, w01:NS, w02:ZE, w10:NS, w11:ZE, w12:PS, w20:ZE, w21:PS, w22:PB}.

Verification
REQ-029 Only w11=0xFFFF -> y=0, den_zero=0, out_valid 27 cycles after accept.
REQ-030 Only w22=0x8000 -> y=30000; only w00=0x8000 -> y=-30000.
REQ-031 w12=0x8000, w22=0x8000 -> y=22500; w00=0x1000, w01=0x3000 -> y=-18750.
REQ-032 All weights 0 -> y=0, den_zero=1, same 27-cycle latency.
REQ-033 out_ready low 10 cycles in DONE -> y/out_valid stable, in_ready=0; then in_valid held high -> next accept one cycle after handshake.
REQ-034 rst_n pulsed low at cycle 12 of DIV -> outputs to reset values immediately, no out_valid; fresh set afterwards gives correct result.
